// File: rtl/spin_pkg.sv
// Shared definitions for the spin-state RAM Avalon-MM responder.
//   DATA_W_DFLT / ADDR_W_DFLT / BURST_W_DFLT : parameter defaults
//   LED_W                                    : width of the LED mirror of word 0
//   spin_state_e                             : responder FSM states
package spin_pkg;

    localparam int unsigned DATA_W_DFLT  = 32;
    localparam int unsigned ADDR_W_DFLT  = 8;
    localparam int unsigned BURST_W_DFLT = 4;
    localparam int unsigned LED_W        = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2
    } spin_state_e;

endpackage

// File: rtl/spin_ram_dp.sv
// Spin-state RAM: simple dual-port memory, written in the M10K-inferable form.
//   clk, reset_n        : clock, synchronous active-low reset (read registers only)
//   host_we/host_be     : byte-enabled write strobe and lanes
//   host_re             : host read strobe, data appears on host_rdata next cycle
//   host_addr/host_wdata: shared host address and write data
//   host_rdata          : host read data (loaded only on host_re)
//   fab_addr/fab_rdata  : fabric read port, 1-cycle latency, old data on collision
// The host never reads and writes in the same cycle, so a host read always sees
// every earlier host write (new-data behaviour). Memory contents survive reset.
module spin_ram_dp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    input  logic [DATA_W/8-1:0]   host_be,
    output logic [DATA_W-1:0]     host_rdata,
    input  logic [ADDR_W-1:0]     fab_addr,
    output logic [DATA_W-1:0]     fab_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents must persist through reset.
    always_ff @(posedge clk) begin
        if (host_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (host_be[i]) begin
                    mem[host_addr][i*8 +: 8] <= host_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Fabric read samples the array before this edge's write lands: old data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            host_rdata <= '0;
            fab_rdata  <= '0;
        end else begin
            if (host_re) begin
                host_rdata <= mem[host_addr];
            end
            fab_rdata <= mem[fab_addr];
        end
    end

endmodule

// File: rtl/spin_ram_avs.sv
// Avalon-MM burst responder giving the HPS lightweight bridge access to the
// spin-state RAM; the annealer fabric reads the same RAM on a second port and
// RAM word 0 bits [9:0] are mirrored onto the board LEDs.
//   clk, reset_n       : single clock, synchronous active-low reset
//   avs_*              : Avalon-MM responder (burst read/write, byteenable)
//   fab_addr/fab_rdata : fabric read port, 1-cycle latency
//   leds               : LED mirror of word 0
// Build option: define SPIN_RAM_AVS_BURST_EN to honour avs_burstcount; when
// undefined every command is a single beat and avs_burstcount is ignored.
module spin_ram_avs
    import spin_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DFLT,
    parameter int unsigned ADDR_W  = ADDR_W_DFLT,
    parameter int unsigned BURST_W = BURST_W_DFLT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic [BURST_W-1:0]    avs_burstcount,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    input  logic [ADDR_W-1:0]     fab_addr,
    output logic [DATA_W-1:0]     fab_rdata,
    output logic [LED_W-1:0]      leds
);

    spin_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    addr_ptr_q, addr_ptr_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic [BURST_W-1:0]   burst_len;

    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    logic                 rd_pend_q;
    logic                 readdatavalid_q;
    logic [DATA_W-1:0]    readdata_q;
    logic [LED_W-1:0]     leds_q, leds_d;
    logic [LED_W-1:0]     led_mask;

`ifdef SPIN_RAM_AVS_BURST_EN
    // A burstcount of 0 is treated as a single beat.
    assign burst_len = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
`else
    logic unused_burstcount;
    assign unused_burstcount = ^avs_burstcount;
    assign burst_len         = BURST_W'(1);
`endif

    always_comb begin
        state_d         = state_q;
        addr_ptr_d      = addr_ptr_q;
        remaining_d     = remaining_q;
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        ram_addr        = addr_ptr_q;
        avs_waitrequest = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write has priority; a simultaneous read is dropped.
                if (avs_write) begin
                    ram_we      = 1'b1;
                    ram_addr    = avs_address;
                    addr_ptr_d  = avs_address + ADDR_W'(1);
                    remaining_d = burst_len - BURST_W'(1);
                    if (burst_len != BURST_W'(1)) begin
                        state_d = WBURST;
                    end
                end else if (avs_read) begin
                    addr_ptr_d  = avs_address;
                    remaining_d = burst_len;
                    state_d     = RBURST;
                end
            end
            WBURST: begin
                // Cycles without avs_write are host gaps; hold everything.
                if (avs_write) begin
                    ram_we      = 1'b1;
                    addr_ptr_d  = addr_ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - BURST_W'(1);
                    if (remaining_q <= BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RBURST: begin
                avs_waitrequest = 1'b1;
                ram_re          = 1'b1;
                addr_ptr_d      = addr_ptr_q + ADDR_W'(1);
                remaining_d     = remaining_q - BURST_W'(1);
                if (remaining_q <= BURST_W'(1)) begin
                    remaining_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LED mirror: merge only the lanes enabled by byteenable[1:0].
    always_comb begin
        led_mask = {{(LED_W-8){avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
        leds_d   = leds_q;
        if (ram_we && (ram_addr == '0)) begin
            leds_d = (leds_q & ~led_mask) | (avs_writedata[LED_W-1:0] & led_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            addr_ptr_q      <= '0;
            remaining_q     <= '0;
            rd_pend_q       <= 1'b0;
            readdatavalid_q <= 1'b0;
            readdata_q      <= '0;
            leds_q          <= '0;
        end else begin
            state_q         <= state_d;
            addr_ptr_q      <= addr_ptr_d;
            remaining_q     <= remaining_d;
            rd_pend_q       <= ram_re;
            readdatavalid_q <= rd_pend_q;
            // readdata holds its last beat while readdatavalid is low.
            if (rd_pend_q) begin
                readdata_q <= ram_rdata;
            end
            leds_q          <= leds_d;
        end
    end

    spin_ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk        (clk),
        .reset_n    (reset_n),
        .host_we    (ram_we & reset_n),
        .host_re    (ram_re),
        .host_addr  (ram_addr),
        .host_wdata (avs_writedata),
        .host_be    (avs_byteenable),
        .host_rdata (ram_rdata),
        .fab_addr   (fab_addr),
        .fab_rdata  (fab_rdata)
    );

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign leds              = leds_q;

endmodule

// File: tb/tb_spin_ram_avs.sv
// Self-checking bench for spin_ram_avs: a reference memory model feeds an
// expected-readdata queue that a negedge monitor pops on every readdatavalid.
module tb_spin_ram_avs;

`ifdef SPIN_RAM_AVS_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [3:0]  avs_burstcount;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  fab_addr;
    logic [31:0] fab_rdata;
    logic [9:0]  leds;

    always #5 clk = ~clk;

    spin_ram_avs #(
        .DATA_W  (32),
        .ADDR_W  (8),
        .BURST_W (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_burstcount    (avs_burstcount),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .fab_addr          (fab_addr),
        .fab_rdata         (fab_rdata),
        .leds              (leds)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] model [256];
    logic [9:0]  led_exp;
    logic [31:0] exp_q [$];
    int          vcyc  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [7:0] addr, input int n, input logic [31:0] first,
                            input logic [3:0] be, input int gap_after);
        logic [7:0]  a;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            d = first + 32'(i);
            check("wr_wait", {31'b0, avs_waitrequest}, 32'd0);
            avs_write      = 1'b1;
            avs_address    = a;
            avs_burstcount = (i == 0) ? 4'(n) : 4'hF;
            avs_writedata  = d;
            avs_byteenable = be;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
            end
            if (a == 8'h00) begin
                if (be[0]) led_exp[7:0] = d[7:0];
                if (be[1]) led_exp[9:8] = d[9:8];
            end
            tick;
            if ((i + 1 == gap_after) && (i != n - 1)) begin
                avs_write   = 1'b0;
                avs_address = 8'h77;
                tick;
            end
        end
        avs_write      = 1'b0;
        avs_burstcount = 4'd0;
    endtask

    task automatic rd_burst(input logic [7:0] addr, input int n);
        int         beats_req;
        int         cmds;
        int         beats;
        int         base;
        int         acc;
        int         total;
        int         wait_cnt;
        logic [7:0] a;
        beats_req = (n == 0) ? 1 : n;
        cmds      = BURST_EN ? 1 : beats_req;
        beats     = BURST_EN ? beats_req : 1;
        total     = cmds * beats;
        base      = vcyc.size();
        acc       = 0;
        a         = addr;
        for (int c = 0; c < cmds; c++) begin
            avs_read       = 1'b1;
            avs_address    = a;
            avs_burstcount = 4'(n);
            for (int k = 0; k < beats; k++) begin
                exp_q.push_back(model[a]);
                a++;
            end
            tick;
            if (c == 0) acc = cyc;
            avs_read    = 1'b0;
            avs_address = 8'h99;
            for (int k = 0; k < beats; k++) begin
                check("rd_wait_hi", {31'b0, avs_waitrequest}, 32'd1);
                tick;
            end
            check("rd_wait_lo", {31'b0, avs_waitrequest}, 32'd0);
        end
        wait_cnt = 0;
        while ((vcyc.size() < base + total) && (wait_cnt < 20)) begin
            tick;
            wait_cnt++;
        end
        check("rd_beats", 32'(vcyc.size() - base), 32'(total));
        if (vcyc.size() >= base + total) begin
            check("rd_latency", 32'(vcyc[base] - acc), 32'd2);
            check("rd_spacing", 32'(vcyc[base+total-1] - vcyc[base]),
                  32'(BURST_EN ? total - 1 : 2 * (total - 1)));
        end
    endtask

    initial begin
        int          base;
        int          wait_cnt;
        int          nb;
        logic [31:0] old;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (avs_readdatavalid === 1'b1) begin
                    vcyc.push_back(cyc);
                    if (exp_q.size() == 0) check("rdv_extra", {31'b0, avs_readdatavalid}, 32'd0);
                    else check("rdata", avs_readdata, exp_q.pop_front());
                end
            end
            begin
                #2000000;
                $display("FAIL timeout: got no finish expected finish");
                $fatal(1);
            end
        join_none

        reset_n        = 1'b0;
        avs_address    = 8'h00;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_writedata  = 32'h0;
        avs_byteenable = 4'h0;
        avs_burstcount = 4'h0;
        fab_addr       = 8'h00;
        led_exp        = 10'h0;
        repeat (3) tick;
        check("rst_wait",  {31'b0, avs_waitrequest},   32'd0);
        check("rst_rdv",   {31'b0, avs_readdatavalid}, 32'd0);
        check("rst_rdata", avs_readdata,               32'd0);
        check("rst_leds",  {22'b0, leds},              32'd0);
        check("rst_fab",   fab_rdata,                  32'd0);
        reset_n = 1'b1;
        tick;

        // Single write to word 0 drives the LEDs, then read it back.
        wr_burst(8'h00, 1, 32'h0000_03A5, 4'hF, 0);
        check("leds_w0", {22'b0, leds}, {22'b0, led_exp});
        rd_burst(8'h00, 1);

        // Burst of 4 with a host gap after beat 2.
        wr_burst(8'h10, 4, 32'd1, 4'hF, 2);
        rd_burst(8'h10, 4);

        // Address wrap 0xFE -> 0xFF -> 0x00; beat 3 lands on word 0.
        wr_burst(8'hFE, 3, 32'h0000_0155, 4'hF, 0);
        check("leds_wrap", {22'b0, leds}, {22'b0, led_exp});
        rd_burst(8'hFE, 3);

        // Partial byteenable merge.
        wr_burst(8'h20, 1, 32'h1234_5678, 4'hF, 0);
        wr_burst(8'h20, 1, 32'hFFFF_FFFF, 4'h2, 0);
        rd_burst(8'h20, 1);

        // Burstcount 0 is a single beat.
        rd_burst(8'h10, 0);

        // Lane 2 only on word 0 leaves the LEDs alone.
        wr_burst(8'h00, 1, 32'h00FF_0000, 4'h4, 0);
        check("leds_lane2", {22'b0, leds}, {22'b0, led_exp});

        // Simultaneous read and write: write wins, read is dropped.
        avs_write      = 1'b1;
        avs_read       = 1'b1;
        avs_address    = 8'h30;
        avs_burstcount = 4'd1;
        avs_writedata  = 32'h0000_C0DE;
        avs_byteenable = 4'hF;
        model[8'h30]   = 32'h0000_C0DE;
        tick;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        check("wr_wins_wait", {31'b0, avs_waitrequest}, 32'd0);
        base = vcyc.size();
        repeat (5) tick;
        check("wr_wins_nordv", 32'(vcyc.size() - base), 32'd0);
        rd_burst(8'h30, 1);

        // Fabric read-during-write returns old data, then the new word.
        wr_burst(8'h05, 1, 32'h0000_0011, 4'hF, 0);
        fab_addr = 8'h05;
        tick;
        check("fab_pre", fab_rdata, model[8'h05]);
        old = model[8'h05];
        wr_burst(8'h05, 1, 32'h0000_00AA, 4'hF, 0);
        check("fab_old", fab_rdata, old);
        tick;
        check("fab_new", fab_rdata, model[8'h05]);

        // Reset in the middle of a read burst.
        wr_burst(8'h40, 8, 32'h0000_00A0, 4'hF, 0);
        base           = vcyc.size();
        nb             = BURST_EN ? 8 : 1;
        avs_read       = 1'b1;
        avs_address    = 8'h40;
        avs_burstcount = 4'd8;
        for (int k = 0; k < nb; k++) exp_q.push_back(model[8'h40 + 8'(k)]);
        tick;
        avs_read = 1'b0;
        if (BURST_EN) begin
            wait_cnt = 0;
            while ((vcyc.size() < base + 2) && (wait_cnt < 20)) begin
                @(negedge clk);
                #1;
                wait_cnt++;
            end
            check("rst_mid_two", 32'(vcyc.size() - base), 32'd2);
        end else begin
            @(negedge clk);
            #1;
        end
        reset_n = 1'b0;
        exp_q.delete();
        led_exp = 10'h0;
        tick;
        tick;
        check("rst_mid_wait", {31'b0, avs_waitrequest},   32'd0);
        check("rst_mid_rdv",  {31'b0, avs_readdatavalid}, 32'd0);
        check("rst_mid_leds", {22'b0, leds},              {22'b0, led_exp});
        reset_n = 1'b1;
        base = vcyc.size();
        repeat (12) tick;
        check("rst_mid_quiet", 32'(vcyc.size() - base), 32'd0);
        rd_burst(8'h42, 1);
        rd_burst(8'h10, 2);

        repeat (4) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
